// File: rtl/linear_layer_fifo_pkg.sv
// Shared sizing helpers for the Linear_Layer start-token FIFOs.
package linear_layer_fifo_pkg;

  // Occupancy counters need one bit more than the store address.
  function automatic int usedw_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // The store must be addressable and hold at least one token.
  function automatic bit depth_ok(input int depth, input int addr_width);
    return (depth >= 1) && (depth <= (1 << addr_width));
  endfunction

endpackage

// File: rtl/linear_layer_start_srl_store.sv
// SRL-style shift store: writes enter entry 0 and push older entries up; read is combinational.
module linear_layer_start_srl_store #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // No reset: contents are only meaningful below the controller's count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  // Addresses past DEPTH only occur while empty, where dout is don't-care.
  always_comb begin
    dout = '0;
    if (int'(addr) < DEPTH) begin
      dout = mem_q[addr];
    end
  end

endmodule

// File: rtl/linear_layer_start_srl_fifo.sv
// Start-token FIFO controller: count tracking, registered full/empty flags, SRL store.
module linear_layer_start_srl_fifo
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   usedw
);

  localparam int UW = usedw_width(ADDR_WIDTH);
  localparam logic [UW-1:0] DEPTH_C = DEPTH[UW-1:0];
  localparam logic [UW-1:0] ONE_C   = 1;

  if (!depth_ok(DEPTH, ADDR_WIDTH)) begin : g_bad_depth
    $error("linear_layer_start_srl_fifo: need 1 <= DEPTH <= 2**ADDR_WIDTH");
  end

  // Handshake: a token moves on a rising edge when the side's request, clock
  // enable and registered flag (full_n / empty_n) are all high; requests made
  // against a low flag are dropped and must be held by the requester.
  logic            push;
  logic            pop;
  logic [UW-1:0]   count_q, count_d;
  logic            empty_n_q, full_n_q;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read  & if_read_ce  & empty_n_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      count_q   <= count_d;
      empty_n_q <= (count_d != '0);
      full_n_q  <= (count_d != DEPTH_C);
    end
  end

  // Oldest token sits at count-1 because every push shifts the store up.
  assign rd_addr = ADDR_WIDTH'(count_q - ONE_C);

  linear_layer_start_srl_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_store (
    .clk  (clk),
    .we   (push),
    .addr (rd_addr),
    .din  (if_din),
    .dout (if_dout)
  );

  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;
  assign usedw      = count_q;

  a_count_range: assert property (@(posedge clk) disable iff (reset)
    count_q <= DEPTH_C);
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && (count_q == '0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count_q == DEPTH_C)));
  a_flags_track: assert property (@(posedge clk) disable iff (reset)
    (empty_n_q == (count_q != '0)) && (full_n_q == (count_q != DEPTH_C)));

endmodule
